// File: rtl/calc_enc_seq_pkg.sv
// Shared calculator definitions: ALU opcode width, button indices and the
// button-combination to opcode encoding.
package calc_pkg;

  localparam int unsigned ALU_OP_W = 4;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_C = 1;
  localparam int unsigned BTN_R = 0;

  localparam alu_op_t OP_NONE = 4'b0000;
  localparam alu_op_t OP_R    = 4'b0001;
  localparam alu_op_t OP_C    = 4'b0010;
  localparam alu_op_t OP_CR   = 4'b0110;
  localparam alu_op_t OP_L    = 4'b0100;
  localparam alu_op_t OP_LR   = 4'b1001;
  localparam alu_op_t OP_LC   = 4'b1010;
  localparam alu_op_t OP_LCR  = 4'b0101;

  function automatic alu_op_t encode_op(input logic [2:0] lcr);
    alu_op_t op;
    unique case (lcr)
      3'b000:  op = OP_NONE;
      3'b001:  op = OP_R;
      3'b010:  op = OP_C;
      3'b011:  op = OP_CR;
      3'b100:  op = OP_L;
      3'b101:  op = OP_LR;
      3'b110:  op = OP_LC;
      default: op = OP_LCR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_enc_seq_if.sv
// Button / opcode bundle between the board buttons and the calculator encoder.
interface calc_enc_seq_if
  import calc_pkg::*;
();

  logic      btnc;
  logic      btnl;
  logic      btnr;
  logic      btnd;
  alu_op_t   alu_op;
  logic      op_valid;
  logic [3:0] btn_stable;

  modport master (
    output btnc, btnl, btnr, btnd,
    input  alu_op, op_valid, btn_stable
  );

  modport slave (
    input  btnc, btnl, btnr, btnd,
    output alu_op, op_valid, btn_stable
  );

endinterface

// File: rtl/calc_enc_seq_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output level only
// changes after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      // any cycle of agreement restarts the count, rejecting short glitches
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign btn_out = stable;

endmodule

// File: rtl/calc_enc_seq.sv
// Debounces the four calculator buttons and encodes {l,c,r} into an ALU opcode,
// either committed on a down-button press or tracked continuously.
module calc_enc_seq
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          COMMIT_MODE     = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  calc_enc_seq_if.slave  bus
);

  logic [3:0] raw;
  logic [3:0] stable;
  logic       btnd_prev;
  logic       commit;
  alu_op_t    lcr_op;
  alu_op_t    op_q, op_d;
  logic       valid_q, valid_d;

  assign raw = {bus.btnd, bus.btnl, bus.btnc, bus.btnr};

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (raw[i]),
      .btn_out (stable[i])
    );
  end

  always_comb begin
    lcr_op  = encode_op({stable[BTN_L], stable[BTN_C], stable[BTN_R]});
    commit  = stable[BTN_D] & ~btnd_prev;
    op_d    = op_q;
    valid_d = commit;
    if (!COMMIT_MODE || commit) begin
      op_d = lcr_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btnd_prev <= 1'b0;
      op_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      btnd_prev <= stable[BTN_D];
      op_q      <= op_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.alu_op     = op_q;
  assign bus.op_valid   = valid_q;
  assign bus.btn_stable = stable;

endmodule

// File: tb/tb_calc_enc_seq.sv
// Directed bench for calc_enc_seq: one commit-mode and one tracking-mode instance
// share the same button stimulus; committed opcodes are checked via scoreboards.
module tb_calc_enc_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic l = 1'b0, c = 1'b0, r = 1'b0, d = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] q1[$];
  logic [3:0] q0[$];

  always #5 clk = ~clk;

  calc_enc_seq_if if1 ();
  calc_enc_seq_if if0 ();

  assign if1.btnl = l;
  assign if1.btnc = c;
  assign if1.btnr = r;
  assign if1.btnd = d;
  assign if0.btnl = l;
  assign if0.btnc = c;
  assign if0.btnr = r;
  assign if0.btnd = d;

  calc_enc_seq #(.DEBOUNCE_CYCLES(4), .COMMIT_MODE(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  calc_enc_seq #(.DEBOUNCE_CYCLES(4), .COMMIT_MODE(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  function automatic logic [3:0] exp_op(input int unsigned lcr);
    case (lcr)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0100;
      5: return 4'b1001;
      6: return 4'b1010;
      default: return 4'b0101;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] op);
    q1.push_back(op);
    q0.push_back(op);
  endtask

  // Scoreboard monitors: every op_valid must match the next queued opcode
  always @(negedge clk) begin
    if (if1.op_valid === 1'b1) begin
      logic       have;
      logic [3:0] e;
      have = (q1.size() != 0);
      e = have ? q1.pop_front() : 4'b0000;
      n_cmp++;
      assert (have && if1.alu_op === e) else begin
        n_bad++;
        $error("FAIL sb_commit: observed op=%0h queued=%0d expected op=%0h", if1.alu_op, have, e);
      end
    end
  end

  always @(negedge clk) begin
    if (if0.op_valid === 1'b1) begin
      logic       have;
      logic [3:0] e;
      have = (q0.size() != 0);
      e = have ? q0.pop_front() : 4'b0000;
      n_cmp++;
      assert (have && if0.alu_op === e) else begin
        n_bad++;
        $error("FAIL sb_track: observed op=%0h queued=%0d expected op=%0h", if0.alu_op, have, e);
      end
    end
  end

  initial begin
    bit rose;
    int unsigned n;

    // 1: reset with all buttons held
    l = 1; c = 1; r = 1; d = 1;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rst_op", if1.alu_op, 4'h0);
      chk("t1_rst_valid", if1.op_valid, 1'b0);
      chk("t1_rst_stable", if1.btn_stable, 4'h0);
    end
    push(4'b0101);
    reset = 0;
    tick(5);
    chk("t1_stable_early", if1.btn_stable, 4'h0);
    tick(1);
    chk("t1_stable", if1.btn_stable, 4'hF);
    tick(1);
    chk("t1_valid", if1.op_valid, 1'b1);
    chk("t1_op", if1.alu_op, 4'b0101);
    l = 0; c = 0; r = 0; d = 0;
    tick(10);

    // 2: commit latching
    l = 1; c = 0; r = 1;
    tick(8);
    push(4'b1001);
    d = 1;
    tick(6);
    chk("t2_valid_early", if1.op_valid, 1'b0);
    tick(1);
    chk("t2_valid", if1.op_valid, 1'b1);
    chk("t2_op", if1.alu_op, 4'b1001);
    chk("t2_valid_trk", if0.op_valid, 1'b1);
    tick(1);
    chk("t2_pulse_len", if1.op_valid, 1'b0);
    tick(2);
    d = 0;
    tick(8);
    l = 0; c = 1; r = 0;
    tick(8);
    chk("t2_hold", if1.alu_op, 4'b1001);
    chk("t2_track", if0.alu_op, 4'b0010);

    // 3: glitch rejection, then a just-long-enough pulse
    rose = 0;
    r = 1;
    tick(3);
    r = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if1.btn_stable[0]) rose = 1;
    end
    chk("t3_glitch", rose, 1'b0);
    chk("t3_op_hold", if1.alu_op, 4'b1001);
    rose = 0;
    r = 1;
    tick(4);
    r = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if1.btn_stable[0]) rose = 1;
    end
    chk("t3_accept", rose, 1'b1);
    tick(10);

    // 4: all eight combinations
    for (int unsigned i = 0; i < 8; i++) begin
      l = i[2]; c = i[1]; r = i[0];
      tick(8);
      push(exp_op(i));
      d = 1;
      tick(8);
      d = 0;
      tick(8);
      chk("t4_op", if1.alu_op, exp_op(i));
    end

    // 5: reset partway through a btnd debounce
    l = 1; c = 0; r = 1;
    tick(8);
    d = 1;
    tick(2);
    reset = 1;
    tick(2);
    chk("t5_rst_op", if1.alu_op, 4'h0);
    chk("t5_rst_valid", if1.op_valid, 1'b0);
    chk("t5_rst_stable", if1.btn_stable, 4'h0);
    push(4'b1001);
    reset = 0;
    tick(3);
    chk("t5_op_early", if1.alu_op, 4'h0);
    n = 0;
    while (q1.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_recommit", q1.size(), 0);
    d = 0;
    tick(10);

    // 6: tracking mode follows the debounced combination one cycle late
    l = 0; c = 0; r = 0;
    tick(10);
    l = 1; c = 1; r = 0;
    n = 0;
    while (if0.btn_stable[2:0] !== 3'b110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_stable", if0.btn_stable[2:0], 3'b110);
    chk("t6_lag", if0.alu_op, 4'b0000);
    tick(1);
    chk("t6_op", if0.alu_op, 4'b1010);
    tick(5);

    chk("end_q1_empty", q1.size(), 0);
    chk("end_q0_empty", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
